// File: rtl/merge_run_feeder_if.sv
// Lane stream and merger-FIFO signals for merge_run_feeder.
// slave: the feeder side; master: the sources/FIFOs side.
interface merge_run_feeder_if #(
  parameter int W = 64
);
  logic [W-1:0] i_src_1_data;
  logic [W-1:0] i_src_2_data;
  logic         i_src_1_valid;
  logic         i_src_2_valid;
  logic         o_src_1_ready;
  logic         o_src_2_ready;
  logic [W-1:0] o_fifo_1_item;
  logic [W-1:0] o_fifo_2_item;
  logic         o_fifo_1_write;
  logic         o_fifo_2_write;
  logic         i_fifo_1_full;
  logic         i_fifo_2_full;

  modport slave (
    input  i_src_1_data, i_src_2_data, i_src_1_valid, i_src_2_valid,
    input  i_fifo_1_full, i_fifo_2_full,
    output o_src_1_ready, o_src_2_ready,
    output o_fifo_1_item, o_fifo_2_item, o_fifo_1_write, o_fifo_2_write
  );

  modport master (
    output i_src_1_data, i_src_2_data, i_src_1_valid, i_src_2_valid,
    output i_fifo_1_full, i_fifo_2_full,
    input  o_src_1_ready, o_src_2_ready,
    input  o_fifo_1_item, o_fifo_2_item, o_fifo_1_write, o_fifo_2_write
  );
endinterface

// File: rtl/merge_run_feeder.sv
// Feeds pairs of sorted runs into the two merger input FIFOs, appending an
// all-zero terminator per lane per run, and reports job completion.
module merge_run_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ITEMS      = 2,
  parameter int LEN_WIDTH  = 16,
  parameter int PAIR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_run_len,
  input  logic [PAIR_WIDTH-1:0] i_num_pairs,
  merge_run_feeder_if.slave     io,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [PAIR_WIDTH-1:0] o_pair_idx,
  output logic                  o_zero_err
);
  localparam int W = DATA_WIDTH * ITEMS;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_e;
  typedef enum logic [1:0] {L_DATA, L_TERM, L_WAIT} lane_state_e;

  top_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0]  run_len_q, run_len_d;
  logic [PAIR_WIDTH-1:0] num_pairs_q, num_pairs_d;
  logic [PAIR_WIDTH-1:0] pair_idx_q, pair_idx_d;
  logic                  zero_err_q, zero_err_d;

  lane_state_e           lane_q [2];
  lane_state_e           lane_d [2];
  logic [LEN_WIDTH-1:0]  cnt_q  [2];
  logic [LEN_WIDTH-1:0]  cnt_d  [2];

  logic [W-1:0] src_data [2];
  logic [W-1:0] item     [2];
  logic         src_valid[2];
  logic         fifo_full[2];
  logic         ready    [2];
  logic         write    [2];
  logic         zero_hit [2];

  logic                  lane_restart;
  logic [LEN_WIDTH-1:0]  restart_len;
  logic                  both_wait;
  logic [PAIR_WIDTH:0]   next_idx;
  logic                  last_pair;

  // Gather the per-lane interface signals into arrays.
  always_comb begin
    src_data[0]  = io.i_src_1_data;
    src_data[1]  = io.i_src_2_data;
    src_valid[0] = io.i_src_1_valid;
    src_valid[1] = io.i_src_2_valid;
    fifo_full[0] = io.i_fifo_1_full;
    fifo_full[1] = io.i_fifo_2_full;
  end

  assign io.o_src_1_ready  = ready[0];
  assign io.o_src_2_ready  = ready[1];
  assign io.o_fifo_1_item  = item[0];
  assign io.o_fifo_2_item  = item[1];
  assign io.o_fifo_1_write = write[0];
  assign io.o_fifo_2_write = write[1];

  assign o_busy     = (state_q != T_IDLE);
  assign o_done     = (state_q == T_DONE);
  assign o_pair_idx = pair_idx_q;
  assign o_zero_err = zero_err_q;

  assign both_wait = (lane_q[0] == L_WAIT) && (lane_q[1] == L_WAIT);
  assign next_idx  = {1'b0, pair_idx_q} + (PAIR_WIDTH+1)'(1);
  // Compare in PAIR_WIDTH+1 bits so a zero pair count counts as "last".
  assign last_pair = (next_idx >= {1'b0, num_pairs_q});

  // Lane FSMs: combinational forwarding, word counting and terminator write.
  always_comb begin
    for (int unsigned l = 0; l < 2; l++) begin
      lane_d[l]   = lane_q[l];
      cnt_d[l]    = cnt_q[l];
      ready[l]    = 1'b0;
      write[l]    = 1'b0;
      item[l]     = '0;
      zero_hit[l] = 1'b0;
      case (lane_q[l])
        L_DATA: begin
          ready[l] = !fifo_full[l];
          item[l]  = src_data[l];
          if (src_valid[l] && !fifo_full[l]) begin
            write[l]    = 1'b1;
            cnt_d[l]    = cnt_q[l] + LEN_WIDTH'(1);
            zero_hit[l] = (src_data[l] == '0);
            if (cnt_q[l] + LEN_WIDTH'(1) == run_len_q) lane_d[l] = L_TERM;
          end
        end
        L_TERM: begin
          write[l] = !fifo_full[l];
          if (!fifo_full[l]) lane_d[l] = L_WAIT;
        end
        default: ;
      endcase
      if (lane_restart) begin
        cnt_d[l]  = '0;
        lane_d[l] = (restart_len == '0) ? L_TERM : L_DATA;
      end
    end
  end

  // Top FSM: job start, pair barrier and completion.
  always_comb begin
    state_d      = state_q;
    run_len_d    = run_len_q;
    num_pairs_d  = num_pairs_q;
    pair_idx_d   = pair_idx_q;
    zero_err_d   = zero_err_q | zero_hit[0] | zero_hit[1];
    lane_restart = 1'b0;
    restart_len  = run_len_q;
    case (state_q)
      T_IDLE: begin
        if (i_start) begin
          run_len_d    = i_run_len;
          num_pairs_d  = i_num_pairs;
          pair_idx_d   = '0;
          zero_err_d   = 1'b0;
          restart_len  = i_run_len;
          // An empty job passes through RUN with both lanes parked in WAIT,
          // which places the done pulse two cycles after start.
          lane_restart = (i_num_pairs != '0);
          state_d      = T_RUN;
        end
      end
      T_RUN: begin
        if (both_wait) begin
          if (last_pair) begin
            state_d = T_DONE;
          end else begin
            pair_idx_d   = next_idx[PAIR_WIDTH-1:0];
            lane_restart = 1'b1;
          end
        end
      end
      T_DONE: state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= T_IDLE;
      run_len_q   <= '0;
      num_pairs_q <= '0;
      pair_idx_q  <= '0;
      zero_err_q  <= 1'b0;
      for (int unsigned l = 0; l < 2; l++) begin
        lane_q[l] <= L_WAIT;
        cnt_q[l]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      num_pairs_q <= num_pairs_d;
      pair_idx_q  <= pair_idx_d;
      zero_err_q  <= zero_err_d;
      for (int unsigned l = 0; l < 2; l++) begin
        lane_q[l] <= lane_d[l];
        cnt_q[l]  <= cnt_d[l];
      end
    end
  end
endmodule
